phase_sequencer: RTL
====================

# phase_sequencer

Parametrised two-road intersection phase controller: eight-phase north/east cycle with built-in tick prescaler, per-phase dwell timers, sensor-gated minimum north green and optional emergency pre-emption to all-red. Sits between the sensor/emergency inputs and the lamp drivers. The lamp and state outputs feed the board LEDs directly; no external counter blocks are needed.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per timer tick (≥2).
- `CNT_W`, 8: phase timer width; every duration parameter < 2^CNT_W.
- `NGREEN_MIN_T`, 10: minimum north-green dwell, ticks (≥1).
- `YELLOW_T`, 3: yellow dwell, ticks (≥1).
- `RED_T`, 2: all-red clearance dwell, ticks (≥1).
- `LEFT_T`, 5: left-turn dwell, ticks (≥1).
- `EGREEN_T`, 10: east-green dwell, ticks (≥1).
- `clk` in 1: clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `sensor` in 1: east-road vehicle request, level.
- `emergency` in 1: emergency pre-emption request, level.
- `state_code` out 4: current phase, 0..8.
- `n_lamp` out 3: north lamps one-hot {red, yellow, green}.
- `e_lamp` out 3: east lamps one-hot {red, yellow, green}.
- `n_left` / `e_left` out 1: left-turn arrow, per road.
- `emerg_active` out 1: high in EMERG.
- `phase_start` out 1: one-cycle pulse on the first cycle of every new phase.

## Operation
- States and codes:
  - `N_GREEN` 0
  - `N_YELLOW` 1
  - `RED_1` 2
  - `E_LEFT` 3
  - `E_GREEN` 4
  - `E_YELLOW` 5
  - `RED_2` 6
  - `N_LEFT` 7
  - `EMERG` 8
- Lamps:
  - `N_GREEN` → n green, e red.
  - `N_YELLOW` → n yellow, e red.
  - `RED_*`, `EMERG` → both red.
  - `E_LEFT` → both red, `e_left`=1.
  - `E_GREEN` → e green, n red.
  - `E_YELLOW` → e yellow, n red.
  - `N_LEFT` → both red, `n_left`=1.
- Prescaler: counts 0..TICK_DIV-1 and emits a tick at TICK_DIV-1. It clears on every phase entry.
- Phase timer: loads duration-1 on entry. It decrements on tick and saturates at 0.
- A phase is done when the timer is 0 and a tick occurs. Every timed phase therefore lasts exactly duration×TICK_DIV cycles.
- Normal sequence: 0→1→2→3→4→5→6→7→0.
  - Every phase except `N_GREEN` advances when done.
  - `N_GREEN` is the rest state. Once done, a min-green-met flag sets and holds. The state leaves on the first cycle with `sensor`=1 and the flag set.
  - A sensor pulse that ends before min-green is met is lost; no latching.
- Emergency pre-emption (priority over sensor and timers), taken on the cycle `emergency`=1:
  - `N_GREEN`, `N_LEFT` → `N_YELLOW`.
  - `E_GREEN`, `E_LEFT` → `E_YELLOW`.
  - `RED_1`, `RED_2` → `EMERG` immediately.
  - Yellow states complete their full dwell, then go to `EMERG` instead of RED while `emergency`=1.
  - `EMERG` holds while `emergency`=1.
  - On deassert, `EMERG` goes to `RED_2` with full RED_T, then continues normally (`N_LEFT` → `N_GREEN`).
- `emergency` deasserting during a yellow state: the normal successor applies.

## Timing
- All state, prescaler and timer flops are reset asynchronously.
- Outputs decode combinationally from the state register only; they are glitch-free per edge.
- Reset values:
  - `state_code`=0, `n_lamp`=3'b001, `e_lamp`=3'b100.
  - `n_left`=`e_left`=0, `emerg_active`=0, `phase_start`=0.
  - Timer loaded with NGREEN_MIN_T-1, prescaler 0, min-green flag 0.
- Reset mid-phase: returns to `N_GREEN` immediately, with no clock edge needed.
- Input-to-state latency: one edge. `sensor`/`emergency` sampled at edge k change `state_code` after edge k.
- `phase_start` is high for the cycle following each transition. It is 0 after reset.
- Simultaneous done and emergency in a green/left state: the emergency target wins.

## Configuration
- `PHASE_SEQ_EMERG_EN` defined: emergency pre-emption as described.
- Not defined:
  - `emergency` is ignored.
  - `EMERG` is unreachable; its logic is removed.
  - `emerg_active` is tied 0.
  - Yellows always go to their RED state.

## Test plan
Parameters for all scenarios: TICK_DIV=4, NGREEN_MIN_T=3, YELLOW_T=2, RED_T=1, LEFT_T=2, EGREEN_T=3.
- Release reset, `sensor`=0 for 100 cycles → `state_code` stays 0, `n_lamp`=001, `e_lamp`=100.
- Sensor held from cycle 2 after reset → `state_code`=1 exactly after the edge at cycle 12, not earlier.
- Sensor held → dwells: 1:8, 2:4, 3:8, 4:12, 5:8, 6:4, 7:8 cycles, then 0. One `phase_start` pulse per entry.
- (EN) Emergency asserted mid `E_GREEN` → `E_YELLOW` next edge, then 8 cycles later `state_code`=8, `emerg_active`=1, both red. Release → `RED_2` for 4 cycles → `N_LEFT`.
- (EN) Emergency asserted in `RED_1` → `state_code`=8 next edge.
- Async `resetn` low mid `E_LEFT` → outputs at reset values before the next clock edge.
- (EN off) Toggle `emergency` randomly during the full cycle → sequence and dwells identical to the full-cycle scenario.

Source files
------------

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - two-road eight-phase intersection controller; macro PHASE_SEQ_EMERG_EN enables emergency pre-emption
module phase_sequencer #(
   parameter int TICK_DIV     = 50_000_000,
   parameter int CNT_W        = 8,
   parameter int NGREEN_MIN_T = 10,
   parameter int YELLOW_T     = 3,
   parameter int RED_T        = 2,
   parameter int LEFT_T       = 5,
   parameter int EGREEN_T     = 10
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       sensor,
   input  logic       emergency,
   output logic [3:0] state_code,
   output logic [2:0] n_lamp,
   output logic [2:0] e_lamp,
   output logic       n_left,
   output logic       e_left,
   output logic       emerg_active,
   output logic       phase_start
);

   localparam int PW = $clog2(TICK_DIV);

   typedef enum logic [3:0] {
      N_GREEN  = 4'd0,
      N_YELLOW = 4'd1,
      RED_1    = 4'd2,
      E_LEFT   = 4'd3,
      E_GREEN  = 4'd4,
      E_YELLOW = 4'd5,
      RED_2    = 4'd6,
      N_LEFT   = 4'd7,
      EMERG    = 4'd8
   } state_t;

   state_t           state;
   state_t           nxt;
   logic             go;
   logic [PW-1:0]    presc;
   logic [CNT_W-1:0] timer;
   logic             min_met;
   logic             tick;
   logic             done;
   logic             emerg_req;

`ifdef PHASE_SEQ_EMERG_EN
   assign emerg_req = emergency;
`else
   // Pre-emption is compiled out; the input is kept only for pin compatibility.
   logic unused_emergency;
   assign unused_emergency = emergency;
   assign emerg_req        = 1'b0;
`endif

   assign tick = (presc == PW'(TICK_DIV - 1));
   assign done = tick && (timer == '0);

   // Timer reload value is the dwell of the phase being entered, minus one.
   function automatic logic [CNT_W-1:0] load_val(input state_t s);
      case (s)
         N_GREEN:            load_val = CNT_W'(NGREEN_MIN_T - 1);
         N_YELLOW, E_YELLOW: load_val = CNT_W'(YELLOW_T - 1);
         E_LEFT, N_LEFT:     load_val = CNT_W'(LEFT_T - 1);
         E_GREEN:            load_val = CNT_W'(EGREEN_T - 1);
         default:            load_val = CNT_W'(RED_T - 1);
      endcase
   endfunction

   // Next-phase selection: emergency beats sensor and timers, go flags a real transition.
   always_comb begin
      nxt = state;
      go  = 1'b0;
      case (state)
         N_GREEN: begin
            if (emerg_req) begin
               nxt = N_YELLOW;
               go  = 1'b1;
            end else if (sensor && (min_met || done)) begin
               nxt = N_YELLOW;
               go  = 1'b1;
            end
         end
         N_YELLOW: begin
            if (done) begin
               nxt = emerg_req ? EMERG : RED_1;
               go  = 1'b1;
            end
         end
         RED_1: begin
            if (emerg_req) begin
               nxt = EMERG;
               go  = 1'b1;
            end else if (done) begin
               nxt = E_LEFT;
               go  = 1'b1;
            end
         end
         E_LEFT: begin
            if (emerg_req) begin
               nxt = E_YELLOW;
               go  = 1'b1;
            end else if (done) begin
               nxt = E_GREEN;
               go  = 1'b1;
            end
         end
         E_GREEN: begin
            if (emerg_req || done) begin
               nxt = E_YELLOW;
               go  = 1'b1;
            end
         end
         E_YELLOW: begin
            if (done) begin
               nxt = emerg_req ? EMERG : RED_2;
               go  = 1'b1;
            end
         end
         RED_2: begin
            if (emerg_req) begin
               nxt = EMERG;
               go  = 1'b1;
            end else if (done) begin
               nxt = N_LEFT;
               go  = 1'b1;
            end
         end
         N_LEFT: begin
            if (emerg_req) begin
               nxt = N_YELLOW;
               go  = 1'b1;
            end else if (done) begin
               nxt = N_GREEN;
               go  = 1'b1;
            end
         end
`ifdef PHASE_SEQ_EMERG_EN
         EMERG: begin
            if (!emerg_req) begin
               nxt = RED_2;
               go  = 1'b1;
            end
         end
`endif
         default: begin
            nxt = N_GREEN;
            go  = 1'b1;
         end
      endcase
   end

   // Phase register with prescaler, dwell timer and min-green flag; all restart on phase entry.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= N_GREEN;
         presc       <= '0;
         timer       <= CNT_W'(NGREEN_MIN_T - 1);
         min_met     <= 1'b0;
         phase_start <= 1'b0;
      end else begin
         phase_start <= go;
         if (go) begin
            state   <= nxt;
            presc   <= '0;
            timer   <= load_val(nxt);
            min_met <= 1'b0;
         end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick && (timer != '0)) begin
               timer <= timer - 1'b1;
            end
            if ((state == N_GREEN) && done) begin
               min_met <= 1'b1;
            end
         end
      end
   end

   // Lamp decode straight from the phase register.
   always_comb begin
      state_code = state;
      n_lamp     = 3'b100;
      e_lamp     = 3'b100;
      n_left     = 1'b0;
      e_left     = 1'b0;
      case (state)
         N_GREEN:  n_lamp = 3'b001;
         N_YELLOW: n_lamp = 3'b010;
         E_GREEN:  e_lamp = 3'b001;
         E_YELLOW: e_lamp = 3'b010;
         E_LEFT:   e_left = 1'b1;
         N_LEFT:   n_left = 1'b1;
         default:  ;
      endcase
   end

`ifdef PHASE_SEQ_EMERG_EN
   assign emerg_active = (state == EMERG);
`else
   assign emerg_active = 1'b0;
`endif

endmodule
